data_mem_sized: RTL
===================

# data_mem_sized

Parametrised successor to the word-only data memory. It adds RISC-V sized loads and stores (byte/half/word, signed and unsigned), a registered read with a valid strobe, and alignment and range checking. A reset-triggered clear sequencer zeroes the array. It sits in the MEM stage: the datapath drives address and store data from the ALU and register file, and funct3 comes straight from the instruction.

## Interface
- DEPTH, 1024: number of 32-bit words; power of two, ≥4.
- ADDR_W, 32: byte-address width; must cover DEPTH*4.
- CLEAR_ON_RESET, 1: 1 = zero the whole array after reset; 0 = array contents undefined, ready right after reset.

- clk  in  1  single clock, rising-edge.
- rst  in  1  synchronous, active-high reset.
- addrIn  in  ADDR_W  byte address.
- dataW  in  32  store data, right-aligned (the byte/half to store sits in the low bits).
- memR  in  1  load request.
- memW  in  1  store request.
- funct3  in  3  access size: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- dataR  out  32  load result, extended to 32 bits.
- rValid  out  1  one-cycle strobe: dataR updated.
- ready  out  1  block accepts requests.
- misalign  out  1  one-cycle strobe: misaligned request rejected.
- accErr  out  1  one-cycle strobe: illegal request rejected.

## Operation
- FSM states: CLEAR, READY.
  - rst → CLEAR with clrIdx=0 if CLEAR_ON_RESET=1, else READY.
- CLEAR state:
  - Each cycle writes 0 to mem[clrIdx] and increments clrIdx.
  - When clrIdx==DEPTH-1, writes that word and moves to READY.
  - memR/memW are ignored: no access, no strobes.
- READY state: a request is sampled when memR|memW is high on a clock edge. Checks are applied in this priority order:
  1. memR&memW both high, funct3 ∉ {000,001,010,100,101}, store with funct3 100/101, or word index addrIn[ADDR_W-1:2] ≥ DEPTH → accErr; no access.
  2. H/HU with addrIn[0]=1, or W with addrIn[1:0]≠0 → misalign; no access.
  3. Otherwise the access is performed.
- Store:
  - SB writes lane addrIn[1:0] with dataW[7:0].
  - SH writes lanes {addrIn[1],0} and {addrIn[1],1} with dataW[15:0].
  - SW writes all four lanes.
  - Other lanes are untouched (per-byte write enables).
- Load:
  - Reads the word, selects the lane by addrIn[1:0].
  - B/H are sign-extended; BU/HU are zero-extended.
- dataR holds its last value between loads and on rejected requests.

## Timing
- Reset values:
  - dataR=0, rValid=0, misalign=0, accErr=0.
  - ready=0 during rst.
  - After reset, ready=1 from the first cycle in READY. With CLEAR_ON_RESET=1 that is DEPTH edges after rst deasserts; with CLEAR_ON_RESET=0 it is the first edge.
- Load latency 1: request at edge N → dataR valid and rValid=1 after edge N+1 (registered output). Back-to-back loads give one result per cycle.
- Store commits at the sampling edge. A load of the same address on the next cycle returns the new data; there is no read-during-write hazard.
- misalign and accErr assert after the edge following the rejected request, for exactly one cycle. rValid=0 on that cycle.
- rst mid-CLEAR restarts from clrIdx=0. rst on the same edge as a request drops the request: no write, no strobe.
- A request on the same edge as the CLEAR→READY transition is ignored.

## Structure
- Shared package data_mem_pkg holds:
  - funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - state enum typedef (ST_CLEAR, ST_READY).
- Sub-module mem_lane_align (combinational):
  - Store direction: produces the 4-bit byte enable and the lane-replicated write word.
  - Load direction: extracts and extends the selected lane.
- Top level holds the FSM, the clear counter, the request checks and the byte-enabled array.

## Test plan
- DEPTH=16, CLEAR_ON_RESET=1: pulse rst, count cycles → ready rises exactly 16 edges after deassert. LW at 0x3C → dataR=0x00000000, rValid one cycle. Requests issued during CLEAR → no strobes.
- SW 0xa28b538c @0x0, then LW @0x0 → 0xa28b538c. LB @0x3 → 0xffffffa2. LBU @0x3 → 0x000000a2. LH @0x2 → 0xffffa28b. LHU @0x0 → 0x0000538c.
- SB 0x00000055 @0x1, then LW @0x0 → 0xa28b558c. SH 0x0000beef @0x2, then LW @0x0 → 0xbeef558c.
- LW @0x3 and SH @0x1 → misalign pulses one cycle each. rValid=0, dataR unchanged, memory word 0 unchanged.
- With DEPTH=16: LW @0x40 → accErr. memR=memW=1 @0x0 → accErr. Store with funct3=100 → accErr. Memory unchanged in all three cases.
- Assert rst midway through CLEAR (cycle 7) → ready stays low for 16 more edges after deassert. Back-to-back LW @0x0, 0x4, 0x8 → three consecutive rValid cycles, each with the correct data.

Source files
------------

// File: rtl/data_mem_pkg.sv
// Shared definitions for the sized data memory.
// Holds the RISC-V load/store funct3 encodings and the controller state type.
package data_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane alignment for sized loads and stores (purely combinational).
//   funct3   : access size (B/H/W/BU/HU)
//   byte_off : low two bits of the byte address
//   st_data  : right-aligned store data
//   st_be    : per-byte write enable for the addressed word
//   st_word  : store data replicated into every candidate lane
//   ld_word  : full word read from the array
//   ld_data  : selected lane, sign- or zero-extended to 32 bits
module mem_lane_align (
  input  logic [2:0]  funct3,
  input  logic [1:0]  byte_off,
  input  logic [31:0] st_data,
  output logic [3:0]  st_be,
  output logic [31:0] st_word,
  input  logic [31:0] ld_word,
  output logic [31:0] ld_data
);
  import data_mem_pkg::*;

  logic [31:0] shifted;

  // Store side: replicate the byte/half across the word so the byte enable
  // alone picks which lanes land in the array.
  always_comb begin
    st_be   = '0;
    st_word = st_data;
    unique case (funct3)
      F3_B: begin
        st_be   = 4'b0001 << byte_off;
        st_word = {4{st_data[7:0]}};
      end
      F3_H: begin
        st_be   = byte_off[1] ? 4'b1100 : 4'b0011;
        st_word = {2{st_data[15:0]}};
      end
      F3_W: begin
        st_be   = '1;
        st_word = st_data;
      end
      default: begin
        st_be   = '0;
        st_word = st_data;
      end
    endcase
  end

  // Load side: shift the addressed lane down to bit 0, then extend.
  always_comb begin
    shifted = ld_word >> {byte_off, 3'b000};
    ld_data = shifted;
    unique case (funct3)
      F3_B:    ld_data = {{24{shifted[7]}}, shifted[7:0]};
      F3_BU:   ld_data = {24'h0, shifted[7:0]};
      F3_H:    ld_data = {{16{shifted[15]}}, shifted[15:0]};
      F3_HU:   ld_data = {16'h0, shifted[15:0]};
      default: ld_data = shifted;
    endcase
  end

endmodule

// File: rtl/data_mem_sized.sv
// Sized RISC-V data memory for the MEM stage.
// Byte/half/word loads and stores with a registered read, alignment and
// range checks, and an optional clear-after-reset sweep of the array.
//   clk, rst  : clock, synchronous active-high reset
//   addrIn    : byte address
//   dataW     : right-aligned store data
//   memR/memW : load / store request
//   funct3    : access size (000 B, 001 H, 010 W, 100 BU, 101 HU)
//   dataR     : registered, extended load result (held between loads)
//   rValid    : one-cycle strobe, dataR updated
//   ready     : block accepts requests
//   misalign  : one-cycle strobe, misaligned request rejected
//   accErr    : one-cycle strobe, illegal request rejected
module data_mem_sized #(
  parameter int unsigned DEPTH          = 1024,
  parameter int unsigned ADDR_W         = 32,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addrIn,
  input  logic [31:0]       dataW,
  input  logic              memR,
  input  logic              memW,
  input  logic [2:0]        funct3,
  output logic [31:0]       dataR,
  output logic              rValid,
  output logic              ready,
  output logic              misalign,
  output logic              accErr
);
  import data_mem_pkg::*;

  localparam int unsigned IDX_W = $clog2(DEPTH);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   clr_idx_q, clr_idx_d;
  logic [31:0]        data_r_q, data_r_d;
  logic               rvalid_q, rvalid_d;
  logic               misalign_q, misalign_d;
  logic               acc_err_q, acc_err_d;

  logic [31:0]        mem_q [DEPTH];

  logic [IDX_W-1:0]   word_idx;
  logic               out_of_range;
  logic               f3_legal;
  logic               req, acc_bad, mis_bad, do_load, do_store;

  logic [3:0]         lane_be;
  logic [31:0]        lane_wdata;
  logic [31:0]        rd_word;
  logic [31:0]        ld_data;

  logic               wr_en;
  logic [IDX_W-1:0]   wr_idx;
  logic [3:0]         wr_be;
  logic [31:0]        wr_data;

  assign word_idx = addrIn[IDX_W+1:2];

  // Any set address bit above the array's index field means the word
  // index is at or beyond DEPTH.
  generate
    if (ADDR_W > IDX_W + 2) begin : g_range
      assign out_of_range = |addrIn[ADDR_W-1:IDX_W+2];
    end else begin : g_no_range
      assign out_of_range = 1'b0;
    end
  endgenerate

  mem_lane_align u_align (
    .funct3   (funct3),
    .byte_off (addrIn[1:0]),
    .st_data  (dataW),
    .st_be    (lane_be),
    .st_word  (lane_wdata),
    .ld_word  (rd_word),
    .ld_data  (ld_data)
  );

  assign rd_word = mem_q[word_idx];

  // Request qualification, highest priority first.
  always_comb begin
    f3_legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
               (funct3 == F3_BU) || (funct3 == F3_HU);
    req      = (state_q == ST_READY) && (memR || memW);
    acc_bad  = (memR && memW) || !f3_legal ||
               (memW && ((funct3 == F3_BU) || (funct3 == F3_HU))) ||
               out_of_range;
    mis_bad  = (((funct3 == F3_H) || (funct3 == F3_HU)) && addrIn[0]) ||
               ((funct3 == F3_W) && (addrIn[1:0] != 2'b00));
    do_load  = req && !acc_bad && !mis_bad && memR;
    do_store = req && !acc_bad && !mis_bad && memW;
  end

  // Controller and output registers next-state.
  always_comb begin
    state_d    = state_q;
    clr_idx_d  = clr_idx_q;
    data_r_d   = data_r_q;
    rvalid_d   = 1'b0;
    misalign_d = 1'b0;
    acc_err_d  = 1'b0;

    unique case (state_q)
      ST_CLEAR: begin
        clr_idx_d = clr_idx_q + IDX_W'(1);
        if (clr_idx_q == IDX_W'(DEPTH - 1)) begin
          state_d   = ST_READY;
          clr_idx_d = '0;
        end
      end
      ST_READY: begin
        if (req) begin
          acc_err_d  = acc_bad;
          misalign_d = !acc_bad && mis_bad;
        end
        if (do_load) begin
          data_r_d = ld_data;
          rvalid_d = 1'b1;
        end
      end
      default: state_d = ST_READY;
    endcase
  end

  // Single write port shared by the clear sweep and stores.
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = word_idx;
    wr_be   = lane_be;
    wr_data = lane_wdata;
    if (state_q == ST_CLEAR) begin
      wr_en   = 1'b1;
      wr_idx  = clr_idx_q;
      wr_be   = '1;
      wr_data = '0;
    end else if (do_store) begin
      wr_en   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= CLEAR_ON_RESET ? ST_CLEAR : ST_READY;
      clr_idx_q  <= '0;
      data_r_q   <= '0;
      rvalid_q   <= 1'b0;
      misalign_q <= 1'b0;
      acc_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_idx_q  <= clr_idx_d;
      data_r_q   <= data_r_d;
      rvalid_q   <= rvalid_d;
      misalign_q <= misalign_d;
      acc_err_q  <= acc_err_d;
    end
  end

  // Array has no reset; a reset edge suppresses any write on that edge.
  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (wr_be[b]) begin
          mem_q[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

  assign dataR    = data_r_q;
  assign rValid   = rvalid_q;
  assign misalign = misalign_q;
  assign accErr   = acc_err_q;
  assign ready    = (state_q == ST_READY) && !rst;

endmodule
